// File: rtl/rename_free_list_if.sv
// Rename free-list port bundle.
//   Requester side (rename + retire) drives: alloc_req, free_valid, free_preg.
//   Free-list side drives: alloc_grant, alloc_preg (combinational),
//                          free_count, empty, overflow_err (registered).
//   master : requester view (rename stage / ROB retire port)
//   slave  : free-list view
interface rename_free_list_if #(
   parameter int unsigned PREG_W = 6
);
   logic              alloc_req;
   logic              alloc_grant;
   logic [PREG_W-1:0] alloc_preg;
   logic              free_valid;
   logic [PREG_W-1:0] free_preg;
   logic [PREG_W:0]   free_count;
   logic              empty;
   logic              overflow_err;

   modport master (
      output alloc_req,
      output free_valid,
      output free_preg,
      input  alloc_grant,
      input  alloc_preg,
      input  free_count,
      input  empty,
      input  overflow_err
   );

   modport slave (
      input  alloc_req,
      input  free_valid,
      input  free_preg,
      output alloc_grant,
      output alloc_preg,
      output free_count,
      output empty,
      output overflow_err
   );
endinterface

// File: rtl/rename_free_list.sv
// rename_free_list: physical-register free list for the rename stage.
// Circular FIFO of unallocated physical tags. Rename pops one tag per cycle
// (first-word-fall-through head), retire pushes one tag per cycle.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   fl   - rename_free_list_if.slave:
//            alloc_req/alloc_grant/alloc_preg  allocation (grant and tag combinational)
//            free_valid/free_preg              tag return from retire
//            free_count/empty/overflow_err     registered status
// Optional feature: define FREELIST_DUP_CHECK_EN to keep an in-list bitmap that
// drops (and flags via overflow_err) frees of tags already present in the list.
module rename_free_list #(
   parameter int unsigned PREG_COUNT = 64,
   parameter int unsigned PREG_W     = 6,
   parameter int unsigned ARCH_COUNT = 32
) (
   input logic               clk,
   input logic               rst,
   rename_free_list_if.slave fl
);
   localparam int unsigned CNT_W      = PREG_W + 1;
   localparam int unsigned INIT_COUNT = PREG_COUNT - ARCH_COUNT;

   logic [PREG_W-1:0] mem [PREG_COUNT];
   logic [PREG_W-1:0] head_q;
   logic [PREG_W-1:0] tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              empty_q;
   logic              overflow_q;

   logic              pop_c;
   logic              free_req_c;
   logic              full_c;
   logic              dup_c;
   logic              push_c;
   logic              drop_c;
   logic [CNT_W-1:0]  count_next_c;
   logic [PREG_W-1:0] head_tag_c;

   // Head entry is always visible; only meaningful while the list is non-empty.
   assign head_tag_c = mem[head_q];

   // Qualified pop/push events; tag 0 is the hardwired x0 mapping and never enters the list.
   always_comb begin
      pop_c        = fl.alloc_req & ~empty_q;
      free_req_c   = fl.free_valid & (fl.free_preg != '0);
      full_c       = (count_q == CNT_W'(PREG_COUNT));
      push_c       = free_req_c & ~full_c & ~dup_c;
      drop_c       = free_req_c & (full_c | dup_c);
      count_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

`ifdef FREELIST_DUP_CHECK_EN
   logic [PREG_COUNT-1:0] in_list_q;

   // A tag leaving through the head this same cycle may legally be returned at once.
   assign dup_c = in_list_q[fl.free_preg] & ~(pop_c & (head_tag_c == fl.free_preg));

   // Membership bitmap; set after clear so a same-cycle pop+free of one tag stays listed.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PREG_COUNT; i++) begin
            in_list_q[i] <= (i >= ARCH_COUNT);
         end
      end else begin
         if (pop_c) begin
            in_list_q[head_tag_c] <= 1'b0;
         end
         if (push_c) begin
            in_list_q[fl.free_preg] <= 1'b1;
         end
      end
   end
`else
   assign dup_c = 1'b0;
`endif

   // Storage and pointers; reset preloads the tags not mapped to architectural registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PREG_COUNT; i++) begin
            mem[i] <= (i < INIT_COUNT) ? PREG_W'(ARCH_COUNT + i) : '0;
         end
         head_q <= '0;
         tail_q <= PREG_W'(INIT_COUNT);
      end else begin
         if (push_c) begin
            mem[tail_q] <= fl.free_preg;
            tail_q      <= tail_q + PREG_W'(1);
         end
         if (pop_c) begin
            head_q <= head_q + PREG_W'(1);
         end
      end
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= CNT_W'(INIT_COUNT);
         empty_q    <= (INIT_COUNT == 0);
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_next_c;
         empty_q    <= (count_next_c == '0);
         overflow_q <= drop_c;
      end
   end

   assign fl.alloc_grant  = pop_c;
   assign fl.alloc_preg   = head_tag_c;
   assign fl.free_count   = count_q;
   assign fl.empty        = empty_q;
   assign fl.overflow_err = overflow_q;

endmodule

// File: tb/tb_rename_free_list.sv
// Testbench for rename_free_list: directed scenarios followed by random traffic,
// checked against a queue-based model of the free list.
module tb_rename_free_list;
   localparam int unsigned PREG_COUNT = 64;
   localparam int unsigned PREG_W     = 6;
   localparam int unsigned ARCH_COUNT = 32;

   logic tb_clk = 1'b0;
   logic rst;
   always #5 tb_clk = ~tb_clk;

   rename_free_list_if #(.PREG_W(PREG_W)) fl_if ();

   rename_free_list #(
      .PREG_COUNT(PREG_COUNT),
      .PREG_W    (PREG_W),
      .ARCH_COUNT(ARCH_COUNT)
   ) dut (
      .clk(tb_clk),
      .rst(rst),
      .fl (fl_if.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the list is an ordered queue of tags.
   logic [PREG_W-1:0] mq [$];
   bit                m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_holds(input logic [PREG_W-1:0] t);
      foreach (mq[i]) if (mq[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_regs(input string tag);
      chk($sformatf("%s.count", tag), 32'(fl_if.free_count), 32'(mq.size()));
      chk($sformatf("%s.empty", tag), 32'(fl_if.empty), 32'(mq.size() == 0));
      chk($sformatf("%s.ovf", tag), 32'(fl_if.overflow_err), 32'(m_ovf));
   endtask

   task automatic do_reset(input string tag);
      rst                = 1'b1;
      fl_if.alloc_req    = 1'b0;
      fl_if.free_valid   = 1'b0;
      fl_if.free_preg    = '0;
      @(posedge tb_clk);
      @(negedge tb_clk);
      rst = 1'b0;
      mq.delete();
      for (int t = ARCH_COUNT; t < PREG_COUNT; t++) mq.push_back(PREG_W'(t));
      m_ovf = 1'b0;
      check_regs(tag);
      #1;
      chk($sformatf("%s.head", tag), 32'(fl_if.alloc_preg), 32'(mq[0]));
   endtask

   // One cycle: drive at negedge, check combinational grant/tag, clock, check status.
   task automatic step(input bit req, input bit fv, input logic [PREG_W-1:0] fp,
                       input string tag);
      int  pre;
      bit  grant;
      bit  ok;
      fl_if.alloc_req  = req;
      fl_if.free_valid = fv;
      fl_if.free_preg  = fp;
      #1;
      pre   = mq.size();
      grant = req && (pre != 0);
      chk($sformatf("%s.grant", tag), 32'(fl_if.alloc_grant), 32'(grant));
      if (pre != 0) chk($sformatf("%s.preg", tag), 32'(fl_if.alloc_preg), 32'(mq[0]));
      if (grant) void'(mq.pop_front());
      ok = fv && (fp != 0) && (pre < PREG_COUNT);
`ifdef FREELIST_DUP_CHECK_EN
      if (ok && model_holds(fp)) ok = 1'b0;
`endif
      if (ok) mq.push_back(fp);
      m_ovf = fv && (fp != 0) && !ok;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_regs(tag);
   endtask

   initial begin
      rst              = 1'b0;
      fl_if.alloc_req  = 1'b0;
      fl_if.free_valid = 1'b0;
      fl_if.free_preg  = '0;
      m_ovf            = 1'b0;
      @(negedge tb_clk);

      // Reset state: 32 free tags starting at 32.
      do_reset("rst");
      chk("rst.tag32", 32'(fl_if.alloc_preg), 32'd32);

      // Drain all 32, then one more request sees empty.
      for (int i = 0; i < 32; i++) step(1'b1, 1'b0, '0, $sformatf("drain%0d", i));
      chk("drain.empty", 32'(fl_if.empty), 32'd1);
      step(1'b1, 1'b0, '0, "drain.extra");

      // No bypass from empty: free 40 with a request, grant next cycle.
      step(1'b1, 1'b1, PREG_W'(40), "nobypass0");
      step(1'b1, 1'b0, '0, "nobypass1");

      // Count 5, simultaneous alloc+free of tag 7, then drain in order.
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, PREG_W'(i), $sformatf("fill5_%0d", i));
      step(1'b1, 1'b1, PREG_W'(7), "simul");
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, $sformatf("simul_drain%0d", i));

      // Tag 0 ignored; fill toward full and push past it; drain with wrap.
      do_reset("rst2");
      step(1'b0, 1'b1, '0, "zero_tag");
      for (int i = 1; i < 32; i++) step(1'b0, 1'b1, PREG_W'(i), $sformatf("fill%0d", i));
      step(1'b0, 1'b1, PREG_W'(1), "fill_last");
      step(1'b0, 1'b1, PREG_W'(2), "over");
      step(1'b0, 1'b0, '0, "over_clear");
      for (int i = 0; i < 66; i++) step(1'b1, 1'b0, '0, $sformatf("wrap%0d", i));

      // Free of a tag already listed right after reset.
      do_reset("rst3");
      step(1'b0, 1'b1, PREG_W'(45), "dup45");
      step(1'b0, 1'b0, '0, "dup45_clear");

      // Random traffic with occasional mid-stream reset.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset($sformatf("rnd_rst%0d", i));
         end else begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                 PREG_W'($urandom_range(0, PREG_COUNT - 1)), $sformatf("rnd%0d", i));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
